timebase_scheduler: RTL and testbench

- Multi-channel timebase controller that replaces free-running per-module dividers with one centrally sequenced block.
- Holds NCH programmable divisors. Generates per-channel single-cycle enable ticks plus a 50%-duty toggle output.
- Accepts divisor reconfiguration through a valid/ready port and applies it glitch-free at each channel's terminal count.
- Sits at the design top. Downstream logic uses tick[] as clock enables on clk_in.

---
 rtl/timebase_scheduler_if.sv | 20 ++
 rtl/timebase_scheduler.sv | 151 +++++++++++++++
 tb/tb_timebase_scheduler.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/timebase_scheduler_if.sv
// Divisor configuration port for timebase_scheduler (valid/ready handshake).
// TIMEBASE_ONESHOT_EN adds the cfg_oneshot request bit.
interface timebase_scheduler_if #(
  parameter int NCH = 4,
  parameter int CW  = 32
);
  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [$clog2(NCH)-1:0] cfg_ch;
  logic [CW-1:0]          cfg_div;
`ifdef TIMEBASE_ONESHOT_EN
  logic                   cfg_oneshot;

  modport master (output cfg_valid, cfg_ch, cfg_div, cfg_oneshot, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_div, cfg_oneshot, output cfg_ready);
`else
  modport master (output cfg_valid, cfg_ch, cfg_div, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_div, output cfg_ready);
`endif
endinterface

// File: rtl/timebase_scheduler.sv
// Multi-channel timebase: per-channel divisor counters producing tick enables and
// 50% toggles, with glitch-free divisor updates. Optional macro: TIMEBASE_ONESHOT_EN.
module timebase_scheduler #(
  parameter int          NCH         = 4,
  parameter int          CW          = 32,
  parameter int unsigned DEFAULT_DIV = 50000000
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  timebase_scheduler_if.slave cfg,
  output logic             running,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   pending
);
  localparam int CHW = $clog2(NCH);

  typedef enum logic {IDLE, RUN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   ctr_q    [NCH];
  logic [CW-1:0]   ctr_d    [NCH];
  logic [CW-1:0]   div_q    [NCH];
  logic [CW-1:0]   div_d    [NCH];
  logic [CW-1:0]   shadow_q [NCH];
  logic [CW-1:0]   shadow_d [NCH];
  logic [NCH-1:0]  tick_q, tick_d;
  logic [NCH-1:0]  clk_q, clk_d;
  logic [NCH-1:0]  pend_q, pend_d;
`ifdef TIMEBASE_ONESHOT_EN
  logic [NCH-1:0]  os_q, os_d;
  logic [NCH-1:0]  done_q, done_d;
`endif
  logic            accept;

  assign running       = (state_q == RUN);
  assign tick          = tick_q;
  assign clk_out       = clk_q;
  assign pending       = pend_q;
  assign cfg.cfg_ready = !(running && pend_q[cfg.cfg_ch]);
  assign accept        = cfg.cfg_valid && cfg.cfg_ready;

  always_comb begin
    state_d  = state_q;
    ctr_d    = ctr_q;
    div_d    = div_q;
    shadow_d = shadow_q;
    tick_d   = '0;
    clk_d    = clk_q;
    pend_d   = pend_q;
`ifdef TIMEBASE_ONESHOT_EN
    os_d     = os_q;
    done_d   = done_q;
`endif

    unique case (state_q)
      IDLE:    if (start && !stop) state_d = RUN;
      RUN:     if (stop)           state_d = IDLE;
      default: state_d = IDLE;
    endcase

    for (int unsigned i = 0; i < NCH; i++) begin
      logic wr;
      logic hold;
      wr   = accept && (cfg.cfg_ch == CHW'(i));
      hold = 1'b0;
`ifdef TIMEBASE_ONESHOT_EN
      hold = os_q[i] && done_q[i];
`endif
      if (state_q == IDLE || state_d == IDLE) begin
        // Idle and the stop edge share the clear; the stop edge also flushes the shadow.
        ctr_d[i]  = '0;
        clk_d[i]  = 1'b0;
        pend_d[i] = 1'b0;
        if (wr) begin
          div_d[i] = cfg.cfg_div;
        end else if (pend_q[i]) begin
          div_d[i] = shadow_q[i];
        end
`ifdef TIMEBASE_ONESHOT_EN
        done_d[i] = 1'b0;
        if (wr) os_d[i] = cfg.cfg_oneshot;
`endif
      end else begin
        if (div_q[i] == '0) begin
          ctr_d[i] = '0;
          if (pend_q[i]) begin
            div_d[i]  = shadow_q[i];
            pend_d[i] = 1'b0;
          end
        end else if (hold) begin
          ctr_d[i] = '0;
        end else if (ctr_q[i] == div_q[i] - CW'(1)) begin
          ctr_d[i]  = '0;
          tick_d[i] = 1'b1;
          clk_d[i]  = ~clk_q[i];
          if (pend_q[i]) begin
            div_d[i]  = shadow_q[i];
            pend_d[i] = 1'b0;
          end
`ifdef TIMEBASE_ONESHOT_EN
          if (os_q[i]) done_d[i] = 1'b1;
`endif
        end else begin
          ctr_d[i] = ctr_q[i] + CW'(1);
        end
        // A write is only accepted with pend_q clear, so it never races the apply above.
        if (wr) begin
          shadow_d[i] = cfg.cfg_div;
          pend_d[i]   = 1'b1;
`ifdef TIMEBASE_ONESHOT_EN
          os_d[i]     = cfg.cfg_oneshot;
          done_d[i]   = 1'b0;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int unsigned i = 0; i < NCH; i++) begin
        ctr_q[i]    <= '0;
        div_q[i]    <= CW'(DEFAULT_DIV);
        shadow_q[i] <= '0;
      end
      tick_q <= '0;
      clk_q  <= '0;
      pend_q <= '0;
`ifdef TIMEBASE_ONESHOT_EN
      os_q   <= '0;
      done_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      div_q    <= div_d;
      shadow_q <= shadow_d;
      tick_q   <= tick_d;
      clk_q    <= clk_d;
      pend_q   <= pend_d;
`ifdef TIMEBASE_ONESHOT_EN
      os_q     <= os_d;
      done_q   <= done_d;
`endif
    end
  end
endmodule

// File: tb/tb_timebase_scheduler.sv
// Directed bench for timebase_scheduler (NCH=4, DEFAULT_DIV=4): vector table plus
// hand-written sequences for pending updates, stop, async reset and one-shot.
module tb_timebase_scheduler;
  logic       clk_in;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       running;
  logic [3:0] tick;
  logic [3:0] clk_out;
  logic [3:0] pending;

  int n_checks = 0;
  int n_fail   = 0;

  timebase_scheduler_if #(.NCH(4), .CW(32)) cfg_if ();

  timebase_scheduler #(.NCH(4), .CW(32), .DEFAULT_DIV(4)) dut (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .cfg     (cfg_if),
    .running (running),
    .tick    (tick),
    .clk_out (clk_out),
    .pending (pending)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        st;
    logic        sp;
    logic        cv;
    logic [1:0]  ch;
    logic [31:0] dv;
    logic        run;
    logic [3:0]  tk;
    logic [3:0]  ck;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(input logic st, input logic sp, input logic cv,
                              input logic [1:0] ch, input logic [31:0] dv,
                              input logic run, input logic [3:0] tk, input logic [3:0] ck);
    vec_t v;
    v.st = st; v.sp = sp; v.cv = cv; v.ch = ch; v.dv = dv;
    v.run = run; v.tk = tk; v.ck = ck;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk_in);
    #1;
  endtask

  // ch0 div=0, ch3 div=1 during the pending-update sequence
  task automatic run_chk(input int k);
    chk($sformatf("E%0d tick0 div0", k), 32'(tick[0]), 32'd0);
    chk($sformatf("E%0d tick3 div1", k), 32'(tick[3]), 32'd1);
    chk($sformatf("E%0d clk_out3", k), 32'(clk_out[3]), 32'(k % 2));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_div   = '0;
`ifdef TIMEBASE_ONESHOT_EN
    cfg_if.cfg_oneshot = 1'b0;
`endif

    vecs[0]  = mk(0, 0, 1, 2'd1, 32'd3, 0, 4'b0000, 4'b0000);
    vecs[1]  = mk(1, 0, 0, 2'd0, 32'd0, 1, 4'b0000, 4'b0000);
    vecs[2]  = mk(0, 0, 0, 2'd0, 32'd0, 1, 4'b0000, 4'b0000);
    vecs[3]  = mk(0, 0, 0, 2'd0, 32'd0, 1, 4'b0000, 4'b0000);
    vecs[4]  = mk(0, 0, 0, 2'd0, 32'd0, 1, 4'b0010, 4'b0010);
    vecs[5]  = mk(0, 0, 0, 2'd0, 32'd0, 1, 4'b1101, 4'b1111);
    vecs[6]  = mk(0, 0, 0, 2'd0, 32'd0, 1, 4'b0000, 4'b1111);
    vecs[7]  = mk(0, 0, 0, 2'd0, 32'd0, 1, 4'b0010, 4'b1101);
    vecs[8]  = mk(0, 0, 0, 2'd0, 32'd0, 1, 4'b0000, 4'b1101);
    vecs[9]  = mk(0, 0, 0, 2'd0, 32'd0, 1, 4'b1101, 4'b0000);
    vecs[10] = mk(0, 0, 0, 2'd0, 32'd0, 1, 4'b0010, 4'b0010);
    vecs[11] = mk(0, 0, 0, 2'd0, 32'd0, 1, 4'b0000, 4'b0010);
    vecs[12] = mk(0, 0, 0, 2'd0, 32'd0, 1, 4'b0000, 4'b0010);
    vecs[13] = mk(0, 0, 0, 2'd0, 32'd0, 1, 4'b1111, 4'b1101);
    vecs[14] = mk(0, 0, 0, 2'd0, 32'd0, 1, 4'b0000, 4'b1101);
    vecs[15] = mk(0, 1, 0, 2'd0, 32'd0, 0, 4'b0000, 4'b0000);
    vecs[16] = mk(1, 1, 0, 2'd0, 32'd0, 0, 4'b0000, 4'b0000);
    vecs[17] = mk(0, 0, 0, 2'd0, 32'd0, 0, 4'b0000, 4'b0000);

    repeat (2) @(posedge clk_in);
    #1;
    chk("reset running", 32'(running), 32'd0);
    chk("reset tick", 32'(tick), 32'd0);
    chk("reset clk_out", 32'(clk_out), 32'd0);
    chk("reset pending", 32'(pending), 32'd0);
    chk("reset cfg_ready", 32'(cfg_if.cfg_ready), 32'd1);
    rst_n = 1'b1;

    // Default divisor 4 on all channels, ch1 reprogrammed to 3 while idle
    for (int i = 0; i < 18; i++) begin
      start            = vecs[i].st;
      stop             = vecs[i].sp;
      cfg_if.cfg_valid = vecs[i].cv;
      cfg_if.cfg_ch    = vecs[i].ch;
      cfg_if.cfg_div   = vecs[i].dv;
      step();
      chk($sformatf("vec%0d running", i), 32'(running), 32'(vecs[i].run));
      chk($sformatf("vec%0d tick", i), 32'(tick), 32'(vecs[i].tk));
      chk($sformatf("vec%0d clk_out", i), 32'(clk_out), 32'(vecs[i].ck));
      chk($sformatf("vec%0d pending", i), 32'(pending), 32'd0);
    end
    start = 1'b0;
    stop  = 1'b0;
    cfg_if.cfg_valid = 1'b0;

    // Idle writes: ch2=10, ch0=0, ch3=1
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch = 2'd2; cfg_if.cfg_div = 32'd10; step();
    cfg_if.cfg_ch = 2'd0; cfg_if.cfg_div = 32'd0;  step();
    cfg_if.cfg_ch = 2'd3; cfg_if.cfg_div = 32'd1;  step();
    cfg_if.cfg_valid = 1'b0;
    chk("idle write pending", 32'(pending), 32'd0);
    start = 1'b1; step(); start = 1'b0;
    chk("run entry running", 32'(running), 32'd1);

    for (int k = 1; k <= 4; k++) begin
      step();
      run_chk(k);
      chk($sformatf("E%0d tick2", k), 32'(tick[2]), 32'd0);
    end
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd2; cfg_if.cfg_div = 32'd2;
    #1;
    chk("first write ready", 32'(cfg_if.cfg_ready), 32'd1);
    step();
    run_chk(5);
    chk("E5 pending2 set", 32'(pending[2]), 32'd1);
    chk("E5 tick2", 32'(tick[2]), 32'd0);
    cfg_if.cfg_div = 32'd7;
    #1;
    chk("second write ready", 32'(cfg_if.cfg_ready), 32'd0);
    for (int k = 6; k <= 10; k++) begin
      step();
      run_chk(k);
      chk($sformatf("E%0d pending2", k), 32'(pending[2]), 32'(k < 10));
      chk($sformatf("E%0d tick2", k), 32'(tick[2]), 32'(k == 10));
    end
    cfg_if.cfg_valid = 1'b0;
    for (int k = 11; k <= 14; k++) begin
      step();
      run_chk(k);
      chk($sformatf("E%0d tick2 div2", k), 32'(tick[2]), 32'(k % 2 == 0));
    end

    // Stop with a pending update: applied on the way to idle
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd2; cfg_if.cfg_div = 32'd6;
    step();
    cfg_if.cfg_valid = 1'b0;
    run_chk(15);
    chk("E15 pending", 32'(pending), 32'b0100);
    stop = 1'b1; step(); stop = 1'b0;
    chk("stop running", 32'(running), 32'd0);
    chk("stop tick", 32'(tick), 32'd0);
    chk("stop clk_out", 32'(clk_out), 32'd0);
    chk("stop pending", 32'(pending), 32'd0);
    start = 1'b1; step(); start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("F%0d tick2 div6", k), 32'(tick[2]), 32'(k == 6));
    end

    // Async reset mid-run discards shadows and restores default divisors
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd1; cfg_if.cfg_div = 32'd9;
    step();
    cfg_if.cfg_valid = 1'b0;
    chk("pre-reset pending1", 32'(pending[1]), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async reset running", 32'(running), 32'd0);
    chk("async reset tick", 32'(tick), 32'd0);
    chk("async reset clk_out", 32'(clk_out), 32'd0);
    chk("async reset pending", 32'(pending), 32'd0);
    chk("async reset cfg_ready", 32'(cfg_if.cfg_ready), 32'd1);
    @(negedge clk_in);
    rst_n = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    chk("post-reset running", 32'(running), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("R%0d tick", k), 32'(tick), (k == 4) ? 32'hF : 32'h0);
      chk($sformatf("R%0d clk_out", k), 32'(clk_out), (k == 4) ? 32'hF : 32'h0);
    end
    stop = 1'b1; step(); stop = 1'b0;

`ifdef TIMEBASE_ONESHOT_EN
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd0; cfg_if.cfg_div = 32'd5;
    cfg_if.cfg_oneshot = 1'b1;
    step();
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_oneshot = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("OS%0d tick0", k), 32'(tick[0]), 32'(k == 5));
      chk($sformatf("OS%0d clk_out0", k), 32'(clk_out[0]), 32'(k >= 5));
    end
    stop = 1'b1; step(); stop = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
